// File: rtl/alu_pkg.sv
// Shared types and defaults for the alu and the two-requester alu_arbiter.
// Holds the FSM state enum, width defaults, opcode constants and the round-robin pick.
package alu_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefOpW   = 3;
  localparam int unsigned NumReq   = 2;
  localparam int unsigned StatCntW = 8;

  typedef enum logic [2:0] {
    AluAdd  = 3'b000,
    AluSub  = 3'b001,
    AluAnd  = 3'b010,
    AluOr   = 3'b011,
    AluXor  = 3'b100,
    AluNor  = 3'b101,
    AluSlt  = 3'b110,
    AluSltu = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } arb_state_e;

  // With both requesters valid the one not granted last wins; otherwise the valid one.
  function automatic logic rr_grant(input logic [NumReq-1:0] valid, input logic last);
    logic g;
    if (&valid) begin
      g = ~last;
    end else begin
      g = valid[1];
    end
    return g;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic/logic ops plus signed/unsigned set-less-than.
// set_o is only raised by the compare opcodes; zero_o flags an all-zero result.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned OP_W   = DefOpW
) (
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] alu_result_o,
  output logic              set_o,
  output logic              zero_o
);

  always_comb begin
    alu_result_o = '0;
    set_o        = 1'b0;
    case (op_i)
      OP_W'(AluAdd): alu_result_o = rs_i + rt_i;
      OP_W'(AluSub): alu_result_o = rs_i - rt_i;
      OP_W'(AluAnd): alu_result_o = rs_i & rt_i;
      OP_W'(AluOr):  alu_result_o = rs_i | rt_i;
      OP_W'(AluXor): alu_result_o = rs_i ^ rt_i;
      OP_W'(AluNor): alu_result_o = ~(rs_i | rt_i);
      OP_W'(AluSlt): begin
        set_o        = $signed(rs_i) < $signed(rt_i);
        alu_result_o = DATA_W'(set_o);
      end
      OP_W'(AluSltu): begin
        set_o        = rs_i < rt_i;
        alu_result_o = DATA_W'(set_o);
      end
      default: begin
        alu_result_o = '0;
        set_o        = 1'b0;
      end
    endcase
  end

  assign zero_o = (alu_result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered alu between two requesters (IDLE/EXEC/RESP).
// Optional per-requester saturating grant counters under macro ALU_ARBITER_STATS_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned OP_W   = DefOpW
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [2*DATA_W-1:0] req_rs_i,
  input  logic [2*DATA_W-1:0] req_rt_i,
  input  logic [2*OP_W-1:0]   req_op_i,
  output logic [1:0]          rsp_valid_o,
  input  logic [1:0]          rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_result_o,
  output logic                rsp_set_o,
`ifdef ALU_ARBITER_STATS_EN
  output logic [15:0]         grant_cnt_o,
`endif
  output logic                rsp_zero_o
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] rs_q, rs_d;
  logic [DATA_W-1:0] rt_q, rt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              set_q, set_d;
  logic              zero_q, zero_d;

  logic              grant;
  logic              req_hs;
  logic [DATA_W-1:0] grant_rs;
  logic [DATA_W-1:0] grant_rt;
  logic [OP_W-1:0]   grant_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_set;
  logic              alu_zero;

  assign grant    = rr_grant(req_valid_i, last_q);
  assign grant_rs = grant ? req_rs_i[DATA_W +: DATA_W] : req_rs_i[0 +: DATA_W];
  assign grant_rt = grant ? req_rt_i[DATA_W +: DATA_W] : req_rt_i[0 +: DATA_W];
  assign grant_op = grant ? req_op_i[OP_W +: OP_W] : req_op_i[0 +: OP_W];

  // State is already IDLE during reset, so ready must also be gated by the reset itself.
  assign req_hs = (state_q == StIdle) && req_valid_i[grant] && rst_n_i;

  alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .rs_i         (rs_q),
    .rt_i         (rt_q),
    .op_i         (op_q),
    .alu_result_o (alu_result),
    .set_o        (alu_set),
    .zero_o       (alu_zero)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    op_d        = op_q;
    result_d    = result_q;
    set_d       = set_q;
    zero_d      = zero_q;
    req_ready_o = '0;
    rsp_valid_o = '0;

    unique case (state_q)
      StIdle: begin
        req_ready_o[grant] = req_hs;
        if (req_hs) begin
          owner_d = grant;
          last_d  = grant;
          rs_d    = grant_rs;
          rt_d    = grant_rt;
          op_d    = grant_op;
          state_d = StExec;
        end
      end
      StExec: begin
        result_d = alu_result;
        set_d    = alu_set;
        zero_d   = alu_zero;
        state_d  = StResp;
      end
      StResp: begin
        rsp_valid_o[owner_q] = 1'b1;
        if (rsp_ready_i[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      op_q     <= '0;
      result_q <= '0;
      set_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      op_q     <= op_d;
      result_q <= result_d;
      set_q    <= set_d;
      zero_q   <= zero_d;
    end
  end

  assign rsp_result_o = result_q;
  assign rsp_set_o    = set_q;
  assign rsp_zero_o   = zero_q;

`ifdef ALU_ARBITER_STATS_EN
  logic [1:0][StatCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (req_hs && (cnt_q[grant] != {StatCntW{1'b1}})) begin
      cnt_d[grant] = cnt_q[grant] + StatCntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the operand and result width.
REQ-002 SHALL have parameter OP_W, default 3, the opcode width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, the reset: asynchronous assert, active-low.
REQ-005 SHALL have port req_valid_i, input, 2, the per-requester operation-valid signals.
REQ-006 SHALL have port req_ready_o, output, 2, the per-requester accept signals.
REQ-007 SHALL have port req_rs_i, input, 2*DATA_W, the per-requester rs operand; requester k is at slice [k*DATA_W +: DATA_W].
REQ-008 SHALL have port req_rt_i, input, 2*DATA_W, the per-requester rt operand, packed as REQ-007.
REQ-009 SHALL have port req_op_i, input, 2*OP_W, the per-requester ALU opcode.
REQ-010 SHALL have port rsp_valid_o, output, 2, the per-requester response-valid signals.
REQ-011 SHALL have port rsp_ready_i, input, 2, the per-requester response-accept signals.
REQ-012 SHALL have port rsp_result_o, output, DATA_W, the registered alu_result_o; shared by both requesters.
REQ-013 SHALL have port rsp_set_o, output, 1, the registered set_o.
REQ-014 SHALL have port rsp_zero_o, output, 1, the registered zero.

Function
REQ-015 SHALL implement an FSM with three states: IDLE, EXEC, RESP.
REQ-016 In IDLE, SHALL assert req_ready_o only on the granted requester, and only when that requester's req_valid_i is high.
REQ-017 SHALL arbitrate round-robin: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-018 On handshake (valid&&ready) in IDLE, SHALL capture rs, rt, op and owner ID, update last-grant, and go to EXEC.
REQ-019 In EXEC, SHALL drive the captured operands into the alu instance, register result/set/zero, and go to RESP.
REQ-020 In RESP, SHALL assert rsp_valid_o[owner] only, holding result/set/zero stable until rsp_ready_i[owner] is high.
REQ-021 SHALL ignore rsp_ready_i of the non-owner.
REQ-022 On rsp_valid&&rsp_ready, SHALL return to IDLE next cycle; a new request can then be accepted in that IDLE cycle.
REQ-023 Latency SHALL be accept at cycle N -> rsp_valid_o at N+2; peak throughput is one operation per 3 cycles.
REQ-024 SHALL keep req_ready_o at 0 outside IDLE.
REQ-025 A requester dropping req_valid_i before handshake SHALL cause no state change.
REQ-026 Operands changing after handshake SHALL NOT affect the in-flight result.

Reset
REQ-027 While rst_n_i is low, SHALL force: state=IDLE, req_ready_o=0, rsp_valid_o=0, rsp_result_o=0, rsp_set_o=0, rsp_zero_o=0, last-grant=1 (requester 0 wins the first contention).
REQ-028 Reset mid-operation (EXEC/RESP) SHALL abort the operation with no response delivered.

Configuration
REQ-029 With macro ALU_ARBITER_STATS_EN defined, SHALL add output grant_cnt_o, 16 bits: two 8-bit saturating counters, counter k at [k*8 +: 8], incremented per handshake of requester k, reset to 0, held at 0xFF.
REQ-030 Without ALU_ARBITER_STATS_EN, SHALL have no grant_cnt_o port and no counter logic.

Structure
REQ-031 A shared package alu_pkg SHALL hold the FSM state enum, the DATA_W/OP_W defaults, and the opcode constants.
REQ-032 SHALL instantiate the existing alu as its single sub-module; no ALU logic is duplicated.

Verification
REQ-033 Reset: rst_n_i low mid-RESP -> all outputs 0 immediately, and no rsp_valid_o after release.
REQ-034 Single request: req0 rs=0x05 rt=0x02 op=3'b010, accepted at N -> rsp_valid_o=2'b01 at N+2, with result/set/zero equal to the alu model.
REQ-035 Contention: both valid continuously from reset -> grant order 0,1,0,1; each response goes only to its owner.
REQ-036 Backpressure: rsp_ready_i[owner]=0 for 5 cycles, non-owner ready=1 -> rsp_valid_o and data held stable, req_ready_o=0, no new accept.
REQ-037 Operand change: req0 rs=0xFF op=3'b110, rs changed to 0x00 the cycle after accept -> result matches 0xFF inputs.
REQ-038 Stats (ALU_ARBITER_STATS_EN): 300 grants to requester 0 -> grant_cnt_o[7:0]=0xFF, grant_cnt_o[15:8]=0.
